// File: rtl/bcd99_count_ctrl.sv
// Sequencer for a two-digit BCD counter: issues clear/enable strobes, stops at a latched target.
// Optional feature macro BCD99_CTRL_AUTO_RELOAD_EN: DONE pulses for one cycle and restarts the run.
module bcd99_count_ctrl #(
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned DIV_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [3:0] target_tens,
  input  logic [3:0] target_units,
  input  logic [3:0] cnt_tens,
  input  logic [3:0] cnt_units,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClr   = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [DIV_W-1:0] PrescLast = DIV_W'(TICK_DIV - 1);

  state_e           state_q;
  logic [DIV_W-1:0] presc_q;
  logic [3:0]       tgt_tens_q;
  logic [3:0]       tgt_units_q;
  logic             at_target;
  logic             go;

  assign at_target = (cnt_tens == tgt_tens_q) && (cnt_units == tgt_units_q);
  // stop outranks start whenever both are asserted
  assign go        = start & ~stop;
  assign state     = state_q;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      tgt_tens_q  <= '0;
      tgt_units_q <= '0;
      cnt_en      <= 1'b0;
      cnt_clr     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      if (clear) begin
        // Abort from any state; in IDLE this is just a bare clear pulse.
        state_q <= StIdle;
        presc_q <= '0;
        cnt_clr <= 1'b1;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (go) begin
              state_q     <= StClr;
              cnt_clr     <= 1'b1;
              busy        <= 1'b1;
              tgt_tens_q  <= clamp_bcd(target_tens);
              tgt_units_q <= clamp_bcd(target_units);
            end
          end
          StClr: begin
            state_q <= StRun;
            presc_q <= '0;
          end
          StRun: begin
            if (stop) begin
              state_q <= StPause;
            end else if (at_target) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (presc_q == PrescLast) begin
              presc_q <= '0;
              cnt_en  <= 1'b1;
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          StPause: begin
            if (go) begin
              state_q <= StRun;
            end
          end
          StDone: begin
`ifdef BCD99_CTRL_AUTO_RELOAD_EN
            done <= 1'b0;
            if (stop) begin
              state_q <= StIdle;
            end else begin
              state_q <= StClr;
              cnt_clr <= 1'b1;
              busy    <= 1'b1;
              if (start) begin
                tgt_tens_q  <= clamp_bcd(target_tens);
                tgt_units_q <= clamp_bcd(target_units);
              end
            end
`else
            if (go) begin
              state_q     <= StClr;
              cnt_clr     <= 1'b1;
              busy        <= 1'b1;
              done        <= 1'b0;
              tgt_tens_q  <= clamp_bcd(target_tens);
              tgt_units_q <= clamp_bcd(target_units);
            end
`endif
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd99_count_ctrl.sv
// Self-checking bench for bcd99_count_ctrl: directed scenarios plus randomized commands,
// all checked cycle by cycle against a behavioural model driving a BCD 0-99 counter.
module tb_bcd99_count_ctrl;

  localparam int unsigned TickDiv = 4;
  localparam int MIdle  = 0;
  localparam int MClr   = 1;
  localparam int MRun   = 2;
  localparam int MPause = 3;
  localparam int MDone  = 4;

  logic       clk = 1'b0;
  logic       reset, start, stop, clear;
  logic [3:0] target_tens, target_units, cnt_tens, cnt_units;
  logic       cnt_en, cnt_clr, busy, done;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses = 0;
  int clr_seen = 0;
  int en_cycles[$];
  int cnt_val;

  // reference model state
  int   m_mode, m_run, m_tgt;
  logic e_en, e_clr, e_busy, e_done;

  always #5 clk = ~clk;

  bcd99_count_ctrl #(
    .TICK_DIV(TickDiv),
    .DIV_W   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .target_tens (target_tens),
    .target_units(target_units),
    .cnt_tens    (cnt_tens),
    .cnt_units   (cnt_units),
    .cnt_en      (cnt_en),
    .cnt_clr     (cnt_clr),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  // counter datapath: BCD 0-99, synchronous clear and enable
  always @(posedge clk or posedge reset) begin
    if (reset) cnt_val <= 0;
    else if (cnt_clr) cnt_val <= 0;
    else if (cnt_en) cnt_val <= (cnt_val == 99) ? 0 : cnt_val + 1;
  end
  assign cnt_tens  = 4'(cnt_val / 10);
  assign cnt_units = 4'(cnt_val % 10);

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  function automatic int outs();
    return int'({state, busy, done, cnt_en, cnt_clr});
  endfunction

  function automatic int exp_outs();
    return int'({3'(m_mode), e_busy, e_done, e_en, e_clr});
  endfunction

  task automatic model_reset();
    m_mode = MIdle; m_run = 0; m_tgt = 0;
    e_en = 0; e_clr = 0; e_busy = 0; e_done = 0;
  endtask

  function automatic int clamped_target();
    int tt, tu;
    tt = int'(target_tens);
    tu = int'(target_units);
    if (tt > 9) tt = 9;
    if (tu > 9) tu = 9;
    return 10 * tt + tu;
  endfunction

  // One clock of controller behaviour; the enable fires on every TickDiv-th counting cycle.
  task automatic model_step();
    e_en = 0;
    e_clr = 0;
    if (clear) begin
      e_clr = 1; m_mode = MIdle; m_run = 0;
    end else begin
      case (m_mode)
        MIdle: if (start && !stop) begin
          m_tgt = clamped_target(); m_mode = MClr; e_clr = 1;
        end
        MClr: begin m_mode = MRun; m_run = 0; end
        MRun: begin
          if (stop) m_mode = MPause;
          else if (cnt_val == m_tgt) m_mode = MDone;
          else begin
            m_run++;
            if (m_run % TickDiv == 0) e_en = 1;
          end
        end
        MPause: if (start && !stop) m_mode = MRun;
        MDone: begin
`ifdef BCD99_CTRL_AUTO_RELOAD_EN
          if (stop) m_mode = MIdle;
          else begin
            if (start) m_tgt = clamped_target();
            m_mode = MClr; e_clr = 1;
          end
`else
          if (start && !stop) begin
            m_tgt = clamped_target(); m_mode = MClr; e_clr = 1;
          end
`endif
        end
        default: m_mode = MIdle;
      endcase
    end
    e_busy = (m_mode == MClr) || (m_mode == MRun) || (m_mode == MPause);
    e_done = (m_mode == MDone);
  endtask

  task automatic cycle(input logic s, input logic p, input logic c);
    start = s; stop = p; clear = c;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (cnt_en) begin
      pulses++;
      en_cycles.push_back(cyc);
    end
    if (cnt_clr) clr_seen++;
    check("cycle_outs", outs(), exp_outs());
    start = 0; stop = 0; clear = 0;
  endtask

  task automatic wait_done(input string tag, input int bound, output int n);
    n = 0;
    while (!done && n < bound) begin
      cycle(0, 0, 0);
      n++;
    end
    check(tag, int'(done), 1);
  endtask

  task automatic wait_pulses(input string tag, input int k, input int bound);
    int n = 0;
    while (pulses < k && n < bound) begin
      cycle(0, 0, 0);
      n++;
    end
    check(tag, pulses, k);
  endtask

  task automatic wait_cnt(input string tag, input int v, input int bound);
    int n = 0;
    while (cnt_val != v && n < bound) begin
      cycle(0, 0, 0);
      n++;
    end
    check(tag, cnt_val, v);
  endtask

  initial begin
    int n, s, bad;
    reset = 1; start = 0; stop = 0; clear = 0;
    target_tens = 0; target_units = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", outs(), 0);
    reset = 0;

    // 1: target 12, single start
    target_tens = 4'd1; target_units = 4'd2;
    pulses = 0; clr_seen = 0; en_cycles.delete();
    cycle(1, 0, 0);
    s = cyc;
    check("t1_clr_state", int'({state, cnt_clr}), int'({3'd1, 1'b1}));
    wait_done("t1_done", 200, n);
    check("t1_pulses", pulses, 12);
    check("t1_count", cnt_val, 12);
    check("t1_status", int'({done, busy, state}), int'({1'b1, 1'b0, 3'd4}));
    check("t1_clr_once", clr_seen, 1);
    check("t1_first_en", en_cycles[0] - s, 1 + TickDiv);
    bad = 0;
    for (int i = 1; i < en_cycles.size(); i++)
      if (en_cycles[i] - en_cycles[i-1] != TickDiv) bad++;
    check("t1_spacing", bad, 0);
`ifndef BCD99_CTRL_AUTO_RELOAD_EN
    repeat (50) cycle(0, 0, 0);
    check("t1_no_extra_en", pulses, 12);
    cycle(0, 1, 0);
    check("t1_stop_ignored", int'(state), 4);
`else
    cycle(0, 0, 1);
`endif

    // 2: pause after fifth enable, then resume
    pulses = 0;
    cycle(1, 0, 0);
    wait_pulses("t2_five", 5, 100);
    cycle(0, 1, 0);
    check("t2_paused", int'(state), 3);
    repeat (20) cycle(0, 0, 0);
    check("t2_hold", pulses, 5);
    cycle(1, 0, 0);
    wait_done("t2_done", 200, n);
    check("t2_pulses", pulses, 12);
    check("t2_count", cnt_val, 12);

    // 3: target 00
    target_tens = 0; target_units = 0;
    pulses = 0;
    cycle(1, 0, 0);
    wait_done("t3_done", 20, n);
    check("t3_latency", n, 2);
    check("t3_pulses", pulses, 0);

    // 4: clear with start during RUN at count 7
    target_tens = 4'd1; target_units = 4'd2;
    cycle(1, 0, 0);
    wait_cnt("t4_reach7", 7, 100);
    cycle(1, 0, 1);
    check("t4_abort", int'({state, busy, done, cnt_clr}), int'({3'd0, 1'b0, 1'b0, 1'b1}));
    cycle(0, 0, 0);
    check("t4_count", cnt_val, 0);
    repeat (3) cycle(0, 0, 0);
    check("t4_idle", int'(state), 0);

    // 5: asynchronous reset between edges mid-RUN
    cycle(1, 0, 0);
    repeat (10) cycle(0, 0, 0);
    #2 reset = 1;
    #1;
    check("t5_async_rst", outs(), 0);
    @(posedge clk);
    #1 reset = 0;
    model_reset();
    repeat (5) cycle(0, 0, 0);
    check("t5_stay_idle", int'({state, busy}), 0);

    // 6: out-of-range target digits clamp to 99
    target_tens = 4'hA; target_units = 4'hF;
    pulses = 0;
    cycle(1, 0, 0);
    wait_done("t6_done", 600, n);
    check("t6_pulses", pulses, 99);
    check("t6_count", cnt_val, 99);
`ifdef BCD99_CTRL_AUTO_RELOAD_EN
    cycle(0, 0, 0);
    check("t6_reload", int'({done, cnt_clr, state}), int'({1'b0, 1'b1, 3'd1}));
    pulses = 0;
    wait_done("t6_done2", 600, n);
    check("t6_pulses2", pulses, 99);
`else
    repeat (5) cycle(0, 0, 0);
    check("t6_sticky", int'({done, state}), int'({1'b1, 3'd4}));
    check("t6_no_wrap", pulses, 99);
`endif

    // randomized commands and targets against the model
    cycle(0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        target_tens  = 4'($urandom_range(0, 2));
        target_units = 4'($urandom_range(0, 15));
      end
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 79) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
